// File: rtl/btn_operand_loader_pkg.sv
// Shared definitions for the button-driven operand loader: button roles,
// debounce state encoding and the default debounce length.
package btn_operand_loader_pkg;

  localparam int BTN_LOAD_A = 0;
  localparam int BTN_LOAD_B = 1;
  localparam int BTN_CLR    = 2;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_e;

endpackage

// File: rtl/btn_operand_loader_debounce.sv
// One push-button channel: 2-flop synchronizer, then a counting debounce FSM
// that outputs the clean level and a single-cycle press strobe on acceptance.
module btn_debounce
  import btn_operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             w_btn_s;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;

  assign w_btn_s = r_sync[1];

  // Bring the raw asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive matching samples; any contrary sample restarts from the old level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOW;
      r_cnt   <= CNT_ZERO;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (w_btn_s) begin
            r_state <= S_RISE;
            r_cnt   <= CNT_ONE;
          end
        end
        S_RISE: begin
          if (!w_btn_s) begin
            r_state <= S_LOW;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_HIGH;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!w_btn_s) begin
            r_state <= S_FALL;
            r_cnt   <= CNT_ONE;
          end
        end
        S_FALL: begin
          if (w_btn_s) begin
            r_state <= S_HIGH;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_LOW;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= CNT_ZERO;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/btn_operand_loader.sv
// Debounced button front end that captures sw into operand registers A/B
// or clears them, flagging each update with a one-cycle upd strobe.
module btn_operand_loader
  import btn_operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DATA_W          = 8,
  parameter int NUM_BTN         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              a_valid,
  output logic              b_valid,
  output logic              upd,
  output logic [NUM_BTN-1:0] btn_db
);

  logic [NUM_BTN-1:0] w_press;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic               r_a_valid;
  logic               r_b_valid;
  logic               r_upd;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (btn[gi]),
      .o_level(btn_db[gi]),
      .o_press(w_press[gi])
    );
  end

  // Operand registers; clear wins over any load accepted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_upd     <= 1'b0;
    end else begin
      r_upd <= |w_press;
      if (w_press[BTN_CLR]) begin
        r_a       <= '0;
        r_b       <= '0;
        r_a_valid <= 1'b0;
        r_b_valid <= 1'b0;
      end else begin
        if (w_press[BTN_LOAD_A]) begin
          r_a       <= sw;
          r_a_valid <= 1'b1;
        end
        if (w_press[BTN_LOAD_B]) begin
          r_b       <= sw;
          r_b_valid <= 1'b1;
        end
      end
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign a_valid = r_a_valid;
  assign b_valid = r_b_valid;
  assign upd     = r_upd;

endmodule
